// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and sizing constants for the DMA sequencer
package dma_pkg;

  localparam int unsigned ADDR_W          = 25;
  localparam int unsigned SECT_BYTES      = 512;
  localparam int unsigned BURST_BYTES     = 128;
  localparam int unsigned BURSTS_PER_SECT = SECT_BYTES / BURST_BYTES;
  localparam int unsigned BCNT_W          = 21;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_BURST  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } dma_state_e;

  function automatic logic [15:0] chunk_size(input logic [31:0] remaining,
                                             input logic [31:0] max_sect);
    return (remaining > max_sect) ? max_sect[15:0] : remaining[15:0];
  endfunction

endpackage

// File: rtl/dma_burst_gen.sv
// rtl/dma_burst_gen.sv - burst address/count generator for one ATA command
module dma_burst_gen
  import dma_pkg::*;
(
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_init,
  input  logic              cnt_load,
  input  logic [BCNT_W-1:0] cnt_init,
  input  logic              enable,
  output logic              burst_val,
  input  logic              burst_rdy,
  output logic [ADDR_W-1:0] burst_addr,
  output logic              burst_last,
  output logic              burst_complete
);

  logic [ADDR_W-1:0] addr_q;
  logic [BCNT_W-1:0] cnt_q;
  logic              fire;

  assign burst_val      = enable && (cnt_q != '0);
  assign burst_last     = burst_val && (cnt_q == BCNT_W'(1));
  assign fire           = burst_val && burst_rdy;
  assign burst_complete = fire && burst_last;
  assign burst_addr     = addr_q;

  // Address is only reloaded per transfer, so chunks continue where the last one stopped.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (addr_load)
        addr_q <= addr_init;
      else if (fire)
        addr_q <= addr_q + ADDR_W'(1);
      if (cnt_load)
        cnt_q <= cnt_init;
      else if (fire)
        cnt_q <= cnt_q - BCNT_W'(1);
    end
  end

endmodule

// File: rtl/dma_sequencer.sv
// rtl/dma_sequencer.sv - splits a DMA transfer into ATA commands and 128-byte bursts
module dma_sequencer
  import dma_pkg::*;
#(
  parameter int unsigned MAX_SECT = 256
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       lba,
  input  logic [31:0]       sector_cnt,
  input  logic              dma_type,
  output logic              dma_done,
  output logic              dma_err,
  output logic              busy,
  output logic              cmd_val,
  input  logic              cmd_rdy,
  output logic [31:0]       cmd_lba,
  output logic [15:0]       cmd_count,
  output logic              cmd_write,
  input  logic              cmd_done,
  input  logic              cmd_err,
  output logic              burst_val,
  input  logic              burst_rdy,
  output logic [ADDR_W-1:0] burst_addr,
  output logic              burst_last
);

  logic [1:0]  rst_sync;
  logic        rst_int_n;
  dma_state_e  state, state_nxt;
  logic [31:0] remaining, lba_q;
  logic        write_q, done_pending, busy_q, done_q, err_q;
  logic        start_ok, cmd_fire, burst_en, burst_complete, done_seen;
  logic [15:0] count_now;

  // Reset asserts asynchronously but releases two clocks later, in step with sclk.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign start_ok  = dma_start && !busy_q && (state == ST_IDLE);
  assign count_now = chunk_size(remaining, 32'(MAX_SECT));
  assign cmd_fire  = cmd_val && cmd_rdy;
  assign done_seen = cmd_done || done_pending;

  always_ff @(posedge sclk or negedge rst_int_n) begin
    if (!rst_int_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (start_ok)
          state_nxt = (sector_cnt == '0) ? ST_FINISH : ST_CMD;
      ST_CMD:
        if (cmd_err)
          state_nxt = ST_FINISH;
        else if (cmd_fire)
          state_nxt = ST_BURST;
      ST_BURST:
        if (cmd_err)
          state_nxt = ST_FINISH;
        else if (burst_complete)
          state_nxt = ST_WAIT;
      ST_WAIT:
        if (cmd_err)
          state_nxt = ST_FINISH;
        else if (done_seen)
          state_nxt = (remaining != '0) ? ST_CMD : ST_FINISH;
      ST_FINISH:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_val  = 1'b0;
    burst_en = 1'b0;
    case (state)
      ST_CMD:   cmd_val  = 1'b1;
      ST_BURST: burst_en = 1'b1;
      default: ;
    endcase
  end

  // busy stays high through the dma_done cycle so a start coinciding with it is dropped.
  always_ff @(posedge sclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      remaining    <= '0;
      lba_q        <= '0;
      write_q      <= 1'b0;
      done_pending <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= (state == ST_FINISH);
      if (start_ok) begin
        remaining <= sector_cnt;
        lba_q     <= lba;
        write_q   <= dma_type;
        err_q     <= 1'b0;
        busy_q    <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
      if (cmd_fire) begin
        remaining <= remaining - 32'(count_now);
        lba_q     <= lba_q + 32'(count_now);
      end
      if (cmd_err && (state != ST_IDLE))
        err_q <= 1'b1;
      case (state)
        ST_CMD, ST_BURST: if (cmd_done) done_pending <= 1'b1;
        default:          done_pending <= 1'b0;
      endcase
    end
  end

  dma_burst_gen u_burst_gen (
    .sclk           (sclk),
    .rst_n          (rst_int_n),
    .addr_load      (start_ok),
    .addr_init      (mem_address),
    .cnt_load       (cmd_fire),
    .cnt_init       (BCNT_W'(count_now) * BCNT_W'(BURSTS_PER_SECT)),
    .enable         (burst_en),
    .burst_val      (burst_val),
    .burst_rdy      (burst_rdy),
    .burst_addr     (burst_addr),
    .burst_last     (burst_last),
    .burst_complete (burst_complete)
  );

  assign dma_done  = done_q;
  assign dma_err   = err_q;
  assign busy      = busy_q;
  assign cmd_lba   = lba_q;
  assign cmd_count = count_now;
  assign cmd_write = write_q;

endmodule

// File: doc/dma_sequencer.md
Name: dma_sequencer

Overview:
- Sits directly downstream of the DMA register block on the sclk domain.
- Consumes its dma_start pulse plus the latched mem_address/lba/sector_cnt/dma_type, and returns a one-cycle dma_done.
- Splits a transfer into ATA commands of at most MAX_SECT sectors, and each command into 128-byte memory burst requests (4 per sector).
- Sequences command issue, burst issue and command completion, aborting on a device error.

Parameters:
- MAX_SECT, 256, max sectors per issued ATA command; range 1..65535.
- BURSTS_PER_SECT, 4, 128-byte bursts per 512-byte sector; fixed, do not override.

Ports:
- sclk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- dma_start  in  1  one-cycle start pulse.
- mem_address  in  25  start address [31:7] (128-byte aligned).
- lba  in  32  start LBA.
- sector_cnt  in  32  total sectors.
- dma_type  in  1  1=write to device, 0=read.
- dma_done  out  1  one-cycle completion pulse.
- dma_err  out  1  status of last transfer; valid from dma_done until next accepted start.
- busy  out  1  transfer in progress.
- cmd_val  out  1  command request valid.
- cmd_rdy  in  1  command accepted when cmd_val&cmd_rdy.
- cmd_lba  out  32  chunk LBA.
- cmd_count  out  16  chunk sectors (1..MAX_SECT).
- cmd_write  out  1  copy of latched dma_type.
- cmd_done  in  1  device completed current command (pulse).
- cmd_err  in  1  device error (pulse); may coincide with cmd_done.
- burst_val  out  1  burst request valid.
- burst_rdy  in  1  burst accepted when burst_val&burst_rdy.
- burst_addr  out  25  burst address [31:7].
- burst_last  out  1  last burst of current command.

Behaviour:
- Reset: all outputs 0, state IDLE. Deassertion of rst_n is synchronised internally. Reset mid-transfer abandons it with no dma_done.
- Start acceptance:
  - dma_start in IDLE latches all inputs, clears dma_err, sets busy next cycle.
  - dma_start while busy is ignored.
  - sector_cnt==0: go to FINISH directly; dma_done exactly 2 cycles after dma_start, no cmd/burst activity.
- States: IDLE -> CMD -> BURST -> WAIT -> (CMD | FINISH) -> IDLE.
- CMD:
  - cmd_val=1; cmd_count=min(remaining, MAX_SECT); cmd_lba=current lba.
  - Outputs are stable while cmd_val&~cmd_rdy.
  - On handshake: remaining-=count, lba+=count (32-bit wrap), burst counter loaded with count*4. Go to BURST.
- BURST:
  - burst_val=1; address stable until handshake.
  - Each handshake: burst_addr+=1 (25-bit wrap modulo 2^25) and burst counter decrements.
  - burst_last=1 on the final burst of the command.
  - After the final handshake go to WAIT. At most one burst per cycle, back-to-back allowed.
- WAIT: leave on cmd_done (or a cmd_done latched earlier). If remaining>0 go to CMD, else go to FINISH.
- cmd_done during CMD/BURST: latched as pending and consumed in WAIT.
- cmd_err in any non-IDLE state:
  - Set dma_err.
  - Drop cmd_val/burst_val next cycle.
  - Go to FINISH; remaining chunks are not issued.
- Simultaneous cmd_err and cmd_done: error wins.
- FINISH: dma_done=1 for one cycle, busy=0 next cycle, return to IDLE. A dma_start in the same cycle as dma_done is ignored.
- Address does not reset between chunks: continues from the last burst+1.
- Width rules:
  - remaining is 32-bit.
  - burst counter is 21-bit (max 65535*4).

Decomposition:
- Shared package dma_pkg holds:
  - state encoding (IDLE, CMD, BURST, WAIT, FINISH);
  - SECT_BYTES=512, BURST_BYTES=128, BURSTS_PER_SECT=4;
  - the ADDR_W=25 constant.
- One sub-module, dma_burst_gen: holds the loadable address/burst counter; emits burst_val, burst_addr and burst_last; handshakes with burst_rdy; reports a burst-complete flag.

Test Plan:
- sector_cnt=0, dma_start -> dma_done 2 cycles later, dma_err=0, no cmd_val/burst_val.
- mem_address=0x10, lba=100, sector_cnt=3, MAX_SECT=256, rdy always 1 -> one cmd (lba 100, count 3); 12 bursts at addr 0x10..0x1B, burst_last on 0x1B; cmd_done -> dma_done, dma_err=0.
- sector_cnt=600, MAX_SECT=256 -> cmds (lba L, 256), (L+256, 256), (L+512, 88); burst addresses continuous; single dma_done after 3rd cmd_done.
- cmd_rdy/burst_rdy randomly stalled -> cmd_lba/cmd_count/burst_addr held stable while valid&~rdy; burst count equals sectors*4.
- cmd_err during BURST of 2nd of 3 chunks -> valids drop next cycle, 3rd cmd never issued, dma_done pulse with dma_err=1; extra dma_start while busy ignored.
- mem_address=0x1FFFFFF, sector_cnt=1 -> burst addresses 0x1FFFFFF, 0x0, 0x1, 0x2; rst_n low mid-transfer -> all outputs 0 immediately, no dma_done.
